// File: rtl/pixel_feeder.sv
// pixel_feeder
// Streams one 5-row image band to a downstream consumer, one column at a
// time. For each column, five rows are read from a synchronous memory
// (1-cycle read latency). They are collected in a shadow register and then
// presented together as one beat on pixel_in0..4 with pixel_valid.
//
// Parameters
//   WIDTH  columns per band (2..1023)
//   AW     memory address width; addresses wrap modulo 2^AW
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   start, band_row     start a band whose top image row is band_row
//   stall               downstream hold; freezes the FSM, counters and read strobe
//   mem_rd, mem_addr    memory read request (row-major: row*WIDTH + col)
//   mem_data            read data, valid one cycle after mem_rd
//   pixel_in0..4        column pixels for rows band_row+0..+4
//   pixel_valid         one beat per issued column
//   load_end            marks the final beat of the band
//   busy, done          activity flag and end-of-band pulse
//
// Build option
//   PIXEL_FEEDER_PAD_EN adds an all-zero column before column 0 and another
//   after column WIDTH-1. The trailing pad column carries load_end.

module pixel_feeder #(
    parameter int WIDTH = 100,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [6:0]    band_row,
    input  logic          stall,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [4:0]    mem_data,
    output logic [4:0]    pixel_in0,
    output logic [4:0]    pixel_in1,
    output logic [4:0]    pixel_in2,
    output logic [4:0]    pixel_in3,
    output logic [4:0]    pixel_in4,
    output logic          pixel_valid,
    output logic          load_end,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_FIN} state_t;

    localparam int            CW       = 10;
    localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
    localparam logic [AW-1:0] W_STEP   = AW'(WIDTH);

    // band_row * WIDTH as a shift-and-add of a constant (no multiplier).
    function automatic logic [AW-1:0] band_base(input logic [6:0] row);
        logic [AW-1:0] acc;
        acc = '0;
        for (int b = 0; b < 7; b++) begin
            if (row[b]) acc = acc + (W_STEP << b);
        end
        return acc;
    endfunction

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [AW-1:0] r_col_addr;   // address of row 0 of the current column
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_rd;
    logic [2:0]    r_rd_row;     // next row to read; 5 means all reads issued
    logic          r_inflight;   // a read fired last cycle; its data is on mem_data now
    logic [2:0]    r_cap_row;
    logic [4:0]    r_shadow [0:4];
    logic [4:0]    r_pix    [0:4];
    logic          r_pixel_valid;
    logic          r_load_end;
    logic          r_busy;
    logic          r_done;
`ifdef PIXEL_FEEDER_PAD_EN
    logic          r_pad_lead;
    logic          r_pad_tail;
`endif

    logic          w_rd_fire;
    logic [4:0]    w_shadow_nxt [0:4];

    // A stalled read is held back and is issued once stall drops.
    assign w_rd_fire = r_mem_rd & ~stall;

    // Shadow contents including the capture in progress. The last row lands
    // on the same edge that moves the column into the pixel outputs.
    always_comb begin
        // NOTE: assign the whole array first so no path leaves it unassigned (no latch).
        w_shadow_nxt = r_shadow;
        if (r_inflight) w_shadow_nxt[r_cap_row] = mem_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_col         <= '0;
            r_col_addr    <= '0;
            r_mem_addr    <= '0;
            r_mem_rd      <= 1'b0;
            r_rd_row      <= '0;
            r_inflight    <= 1'b0;
            r_cap_row     <= '0;
            r_pixel_valid <= 1'b0;
            r_load_end    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            // NOTE: these small arrays are flops, not RAM, so clearing them on reset is cheap and required.
            for (int i = 0; i < 5; i++) begin
                r_shadow[i] <= '0;
                r_pix[i]    <= '0;
            end
`ifdef PIXEL_FEEDER_PAD_EN
            r_pad_lead    <= 1'b0;
            r_pad_tail    <= 1'b0;
`endif
        end else begin
            // Data from a read that fired last cycle is captured even while stalled.
            r_shadow   <= w_shadow_nxt;
            r_inflight <= w_rd_fire;
            r_cap_row  <= r_rd_row;

            if (!stall) begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_busy     <= 1'b1;
                            r_col      <= '0;
                            r_col_addr <= band_base(band_row);
                            r_mem_addr <= band_base(band_row);
                            r_rd_row   <= '0;
`ifdef PIXEL_FEEDER_PAD_EN
                            r_state       <= S_ISSUE;
                            r_pad_lead    <= 1'b1;
                            r_pixel_valid <= 1'b1;
                            for (int i = 0; i < 5; i++) r_pix[i] <= '0;
`else
                            r_state  <= S_FETCH;
                            r_mem_rd <= 1'b1;
`endif
                        end
                    end

                    S_FETCH: begin
                        if (r_mem_rd) begin
                            r_rd_row <= r_rd_row + 3'd1;
                            if (r_rd_row == 3'd4) r_mem_rd   <= 1'b0;
                            else                  r_mem_addr <= r_mem_addr + W_STEP;
                        end
                        // All reads issued means the last capture is happening now.
                        if (r_rd_row == 3'd5) begin
                            r_state       <= S_ISSUE;
                            r_pix         <= w_shadow_nxt;
                            r_pixel_valid <= 1'b1;
`ifdef PIXEL_FEEDER_PAD_EN
                            r_load_end    <= 1'b0;
`else
                            r_load_end    <= (r_col == LAST_COL);
`endif
                        end
                    end

                    S_ISSUE: begin
                        r_pixel_valid <= 1'b0;
                        r_load_end    <= 1'b0;
`ifdef PIXEL_FEEDER_PAD_EN
                        if (r_pad_lead) begin
                            r_pad_lead <= 1'b0;
                            r_state    <= S_FETCH;
                            r_mem_rd   <= 1'b1;
                            r_rd_row   <= '0;
                        end else if (r_pad_tail) begin
                            r_pad_tail <= 1'b0;
                            r_state    <= S_FIN;
                            r_done     <= 1'b1;
                        end else
`endif
                        if (r_col != LAST_COL) begin
                            r_col      <= r_col + CW'(1);
                            r_col_addr <= r_col_addr + AW'(1);
                            r_mem_addr <= r_col_addr + AW'(1);
                            r_mem_rd   <= 1'b1;
                            r_rd_row   <= '0;
                            r_state    <= S_FETCH;
                        end else begin
`ifdef PIXEL_FEEDER_PAD_EN
                            // Trailing pad column: stay in ISSUE for one more beat.
                            r_pad_tail    <= 1'b1;
                            r_pixel_valid <= 1'b1;
                            r_load_end    <= 1'b1;
                            for (int i = 0; i < 5; i++) r_pix[i] <= '0;
`else
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
`endif
                        end
                    end

                    S_FIN: begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign mem_rd      = w_rd_fire;
    assign mem_addr    = r_mem_addr;
    assign pixel_in0   = r_pix[0];
    assign pixel_in1   = r_pix[1];
    assign pixel_in2   = r_pix[2];
    assign pixel_in3   = r_pix[3];
    assign pixel_in4   = r_pix[4];
    assign pixel_valid = r_pixel_valid;
    assign load_end    = r_load_end;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_pixel_feeder.sv
// Self-checking bench for pixel_feeder (WIDTH=4, AW=14). The memory model
// returns mem[a] = a[4:0]. Expected beats are queued when a band is
// started. A negedge monitor pops and compares every beat that is
// presented while stall is low.
module tb_pixel_feeder;

    localparam int W  = 4;
    localparam int AW = 14;
`ifdef PIXEL_FEEDER_PAD_EN
    localparam bit PAD = 1'b1;
    localparam int OFS = 1;
`else
    localparam bit PAD = 1'b0;
    localparam int OFS = 0;
`endif
    localparam int LAT = 7*W + 1 + 2*OFS;

    typedef struct packed {
        logic [4:0] p0, p1, p2, p3, p4;
        logic       le;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset, start, stall;
    logic [6:0]    band_row;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [4:0]    mem_data = 5'd0;
    logic [4:0]    pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4;
    logic          pixel_valid, load_end, busy, done;

    pixel_feeder #(.WIDTH(W), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .band_row(band_row), .stall(stall),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .pixel_in0(pixel_in0), .pixel_in1(pixel_in1), .pixel_in2(pixel_in2),
        .pixel_in3(pixel_in3), .pixel_in4(pixel_in4),
        .pixel_valid(pixel_valid), .load_end(load_end), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            start_cyc = 0;
    int            done_cnt = 0;
    int            done_at  = 0;
    beat_t         sb [$];
    logic [AW-1:0] rd_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory: one-cycle read latency, garbage when no read fired.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        mem_data <= mem_rd ? mem_addr[4:0] : 5'h1f;
    end

    // Monitor: scoreboard comparison, done tracking, read address log.
    always @(negedge clk) begin
        if (!reset) begin
            if (load_end && !pixel_valid) check("load_end_without_valid", 32'(load_end), 32'd0);
            if (pixel_valid && !stall) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat_unexpected: got 0x%0h expected none",
                             {pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4, load_end});
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check("beat", 32'({pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4, load_end}),
                          32'(e));
                end
            end
            if (done) begin
                done_cnt++;
                done_at = cyc - start_cyc;
            end
            if (mem_rd) rd_log.push_back(mem_addr);
        end
    end

    function automatic beat_t col_beat(input int row, input int c, input bit le);
        beat_t b;
        b.p0 = 5'(((row + 0)*W + c) % 32);
        b.p1 = 5'(((row + 1)*W + c) % 32);
        b.p2 = 5'(((row + 2)*W + c) % 32);
        b.p3 = 5'(((row + 3)*W + c) % 32);
        b.p4 = 5'(((row + 4)*W + c) % 32);
        b.le = le;
        return b;
    endfunction

    task automatic push_band(input int row);
        beat_t z;
        z = '0;
        if (PAD) sb.push_back(z);
        for (int c = 0; c < W; c++) sb.push_back(col_beat(row, c, !PAD && (c == W-1)));
        if (PAD) begin
            z.le = 1'b1;
            sb.push_back(z);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int row);
        band_row  = 7'(row);
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic finish_band(input string name, input int d0, input int exp_lat);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done expected done", name);
        end else begin
            check({name, "_latency"}, 32'(done_at), 32'(exp_lat));
        end
        repeat (3) tick();
        @(negedge clk);
        check({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_beats_left"}, 32'(sb.size()), 32'd0);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
        tick();
    endtask

    initial begin
        int    d0;
        beat_t h;
        int    exp_a [5];
        exp_a = '{8, 12, 16, 20, 24};

        reset = 1'b1; start = 1'b0; stall = 1'b0; band_row = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_pix", 32'({pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4}), 32'd0);
        check("rst_ctrl", 32'({mem_rd, pixel_valid, load_end, busy, done}), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Band at row 0: first column 0,4,8,12,16.
        d0 = done_cnt;
        push_band(0);
        do_start(0);
        @(negedge clk);
        check("t1_busy", 32'(busy), 32'd1);
        finish_band("t1", d0, LAT);
        h = col_beat(0, W-1, 1'b0);
        if (PAD) h = '0;
        check("t1_hold_pix", 32'({pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4}), 32'(h >> 1));

        // Band at row 2: first reads 8,12,16,20,24.
        rd_log.delete();
        d0 = done_cnt;
        push_band(2);
        do_start(2);
        finish_band("t2", d0, LAT);
        check("t2_read_count", 32'(rd_log.size()), 32'(5*W));
        for (int i = 0; i < 5; i++) check("t2_addr", 32'(rd_log[i]), 32'(exp_a[i]));

        // Stall three cycles in the middle of the first column fetch (row 2 pending).
        d0 = done_cnt;
        push_band(1);
        do_start(1);
        repeat (2 + OFS) tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_stall_rd", 32'(mem_rd), 32'd0);
            check("t3_stall_addr", 32'(mem_addr), 32'd12);
            tick();
        end
        stall = 1'b0;
        finish_band("t3", d0, LAT + 3);

        // Stall two cycles while column 1 is being issued.
        d0 = done_cnt;
        push_band(0);
        do_start(0);
        repeat (13 + OFS) tick();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t4_valid_held", 32'(pixel_valid), 32'd1);
            check("t4_pix0_held", 32'(pixel_in0), 32'd1);
            tick();
        end
        stall = 1'b0;
        finish_band("t4", d0, LAT + 2);

        // A second start while busy is ignored.
        d0 = done_cnt;
        push_band(3);
        do_start(3);
        repeat (9) tick();
        band_row = 7'd5;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        finish_band("t5", d0, LAT);

        // Reset during the second column fetch, then a fresh full band.
        push_band(0);
        do_start(0);
        repeat (9 + OFS) tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("t6_rst_pix", 32'({pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4}), 32'd0);
        check("t6_rst_ctrl", 32'({mem_rd, pixel_valid, load_end, busy, done}), 32'd0);
        check("t6_rst_addr", 32'(mem_addr), 32'd0);
        sb.delete();
        tick();
        reset = 1'b0;
        tick();
        d0 = done_cnt;
        push_band(0);
        do_start(0);
        finish_band("t6", d0, LAT);

        // Reset and start together: reset wins.
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("t7_busy", 32'(busy), 32'd0);
        repeat (2) tick();
        @(negedge clk);
        check("t7_idle", 32'({mem_rd, busy, pixel_valid}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
